// File: rtl/led_pwm_pkg.sv
// Shared constants and enums for the LED PWM controller slice.
// The breathe feature is compiled only when LED_PWM_BREATHE_EN is defined.
package led_pwm_pkg;

  localparam int DEF_NUM_CH   = 8;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_PRESCALE = 4;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_PWM    = 1'b1
  } led_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } breathe_dir_e;

  // Prescaler register width; a PRESCALE of 1 still needs a 1-bit register.
  function automatic int presc_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/led_pwm_ctrl_sync_2ff.sv
// Two-flop synchronizer for the asynchronous PWM/direct board switch.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED PWM controller with shadowed duty registers and a synced mode switch.
// Optional per-channel breathe mode is compiled in when LED_PWM_BREATHE_EN is defined.
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [4:0]        wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  output logic              wr_err,
  input  logic [NUM_CH-1:0] direct_leds,
  input  logic              sel_pwm,
  input  logic [NUM_CH-1:0] breathe_mask,
  output logic [NUM_CH-1:0] leds,
  output logic              period_tick
);

  localparam int               PW         = presc_width(PRESCALE);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [5:0]       NUM_CH_L   = 6'(NUM_CH);

  logic [PW-1:0]     presc_q, presc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              step;
  logic              wrap;
  logic              wr_ok;
  logic              wr_bad;
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  active_q [NUM_CH];
  logic [NUM_CH-1:0] pwm;
  logic [NUM_CH-1:0] leds_q, leds_d;
  logic              period_tick_q;
  logic              wr_err_q, wr_err_d;
  logic              sel_sync;
  led_mode_e         mode;

  sync_2ff u_sel_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (sel_pwm),
    .q_o   (sel_sync)
  );

  // Handshake: wr_ready is constantly 1, so every cycle with wr_valid=1 is an accepted write.
  always_comb begin
    step     = (presc_q == PRESC_LAST);
    presc_d  = step ? '0 : presc_q + 1'b1;
    cnt_d    = step ? cnt_q + 1'b1 : cnt_q;
    wrap     = step && (cnt_q == CNT_MAX);
    wr_ok    = wr_valid && ({1'b0, wr_addr} < NUM_CH_L);
    wr_bad   = wr_valid && !({1'b0, wr_addr} < NUM_CH_L);
    wr_err_d = wr_err_q | wr_bad;
    mode     = led_mode_e'(sel_sync);
    pwm      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm[i] = (cnt_q < active_q[i]);
    end
    leds_d = (mode == MODE_PWM) ? pwm : direct_leds;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q       <= '0;
      cnt_q         <= '0;
      leds_q        <= '0;
      period_tick_q <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      cnt_q         <= cnt_d;
      leds_q        <= leds_d;
      period_tick_q <= wrap;
      wr_err_q      <= wr_err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_ok && (wr_addr == 5'(i))) begin
          shadow_q[i] <= wr_data;
        end
      end
    end
  end

  // Active duties change only on the wrap edge; a same-edge write is seen next period.
`ifdef LED_PWM_BREATHE_EN
  breathe_dir_e dir_q [NUM_CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        active_q[i] <= '0;
        dir_q[i]    <= DIR_UP;
      end
    end else if (wrap) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (breathe_mask[i]) begin
          if (dir_q[i] == DIR_UP) begin
            if (active_q[i] == CNT_MAX) begin
              dir_q[i]    <= DIR_DOWN;
              active_q[i] <= active_q[i] - 1'b1;
            end else begin
              active_q[i] <= active_q[i] + 1'b1;
            end
          end else begin
            if (active_q[i] == '0) begin
              dir_q[i]    <= DIR_UP;
              active_q[i] <= active_q[i] + 1'b1;
            end else begin
              active_q[i] <= active_q[i] - 1'b1;
            end
          end
        end else begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end
`else
  logic unused_breathe_mask;
  assign unused_breathe_mask = ^breathe_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        active_q[i] <= '0;
      end
    end else if (wrap) begin
      for (int i = 0; i < NUM_CH; i++) begin
        active_q[i] <= shadow_q[i];
      end
    end
  end
`endif

  assign wr_ready    = 1'b1;
  assign wr_err      = wr_err_q;
  assign leds        = leds_q;
  assign period_tick = period_tick_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl at default parameters (1024-cycle PWM period).
// Define LED_PWM_BREATHE_EN for both RTL and bench to include the breathe steps.
module tb_led_pwm_ctrl;

  localparam int NUM_CH = 8;
  localparam int CNT_W  = 8;
  localparam int PERIOD = 1024;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [4:0]        wr_addr = '0;
  logic [CNT_W-1:0]  wr_data = '0;
  logic              wr_err;
  logic [NUM_CH-1:0] direct_leds = '0;
  logic              sel_pwm = 1'b0;
  logic [NUM_CH-1:0] breathe_mask = '0;
  logic [NUM_CH-1:0] leds;
  logic              period_tick;

  int total = 0;
  int bad   = 0;
  int hi_cnt [NUM_CH];
  int tick_cnt;

  led_pwm_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_err       (wr_err),
    .direct_leds  (direct_leds),
    .sel_pwm      (sel_pwm),
    .breathe_mask (breathe_mask),
    .leds         (leds),
    .period_tick  (period_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write_duty(input logic [4:0] addr, input logic [CNT_W-1:0] data);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = addr;
    wr_data  = data;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Returns at the negedge of the next period_tick cycle, bounded.
  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge clk);
    while (period_tick !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    check("tick_seen", {31'd0, period_tick}, 32'd1);
  endtask

  // Called at a tick negedge; counts LED-high cycles over one full period.
  task automatic measure();
    for (int i = 0; i < NUM_CH; i++) hi_cnt[i] = 0;
    tick_cnt = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) hi_cnt[i] += int'(leds[i]);
      tick_cnt += int'(period_tick);
    end
    check("tick_once_per_period", tick_cnt, 1);
  endtask

  initial begin
    int n;
    int act;

    repeat (3) @(negedge clk);
    check("reset_leds", {24'd0, leds}, 32'd0);
    check("reset_tick", {31'd0, period_tick}, 32'd0);
    check("reset_err", {31'd0, wr_err}, 32'd0);
    check("wr_ready_high", {31'd0, wr_ready}, 32'd1);
    reset = 1'b0;

    // 50% duty on ch0, 200/256 on ch1
    write_duty(5'd0, 8'd128);
    write_duty(5'd1, 8'd200);
    sel_pwm = 1'b1;
    wait_tick();
    measure();
    check("ch0_duty128", hi_cnt[0], 512);
    check("ch1_duty200", hi_cnt[1], 800);

    // duty 0 and full-scale
    write_duty(5'd1, 8'd0);
    write_duty(5'd2, 8'd255);
    wait_tick();
    measure();
    check("ch0_hold", hi_cnt[0], 512);
    check("ch1_duty0", hi_cnt[1], 0);
    check("ch2_duty255", hi_cnt[2], 1020);

    // write ch3 exactly in the wrap cycle
    repeat (1023) @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 8'd64;
    @(negedge clk);
    wr_valid = 1'b0;
    check("wrap_cycle_tick", {31'd0, period_tick}, 32'd1);
    measure();
    check("ch3_old_value", hi_cnt[3], 0);
    measure();
    check("ch3_new_value", hi_cnt[3], 256);
    check("ch0_after_wrapwrite", hi_cnt[0], 512);

    // out-of-range address
    write_duty(5'd9, 8'hAA);
    check("err_set", {31'd0, wr_err}, 32'd1);
    wait_tick();
    measure();
    check("badaddr_ch0", hi_cnt[0], 512);
    check("badaddr_ch1", hi_cnt[1], 0);
    check("badaddr_ch2", hi_cnt[2], 1020);
    check("badaddr_ch3", hi_cnt[3], 256);
    for (int i = 4; i < NUM_CH; i++) check("badaddr_upper", hi_cnt[i], 0);
    check("err_sticky", {31'd0, wr_err}, 32'd1);

    // asynchronous switch to direct mode
    @(negedge clk);
    direct_leds = 8'h5A;
    #2 sel_pwm = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("direct_within_3", {24'd0, leds}, 32'h5A);
    @(negedge clk);
    direct_leds = 8'hA5;
    @(negedge clk);
    check("direct_latency1", {24'd0, leds}, 32'hA5);

    // mid-period reset
    direct_leds = 8'h00;
    sel_pwm = 1'b1;
    repeat (300) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_leds", {24'd0, leds}, 32'd0);
    check("midreset_tick", {31'd0, period_tick}, 32'd0);
    check("midreset_err", {31'd0, wr_err}, 32'd0);
    check("midreset_cnt", {24'd0, dut.cnt_q}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    act = 0;
    while (period_tick !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
      if (leds !== '0) act++;
    end
    check("restart_tick_cycles", n, PERIOD);
    check("no_pulse_after_reset", act, 0);
    measure();
    check("post_reset_ch0", hi_cnt[0], 0);
    check("post_reset_ch3", hi_cnt[3], 0);

`ifdef LED_PWM_BREATHE_EN
    write_duty(5'd4, 8'd254);
    wait_tick();
    check("breathe_start", {24'd0, dut.active_q[4]}, 32'd254);
    breathe_mask[4] = 1'b1;
    write_duty(5'd4, 8'd10);
    wait_tick();
    check("breathe_up_255", {24'd0, dut.active_q[4]}, 32'd255);
    wait_tick();
    check("breathe_down_254", {24'd0, dut.active_q[4]}, 32'd254);
    wait_tick();
    check("breathe_down_253", {24'd0, dut.active_q[4]}, 32'd253);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
